rtype_seq_ctrl: RTL

Multi-cycle sequencer that fetches 32-bit MIPS R-type instructions from a synchronous instruction ROM, decodes them, and drives the register-file/ALU datapath: read addresses, ALU operation, write address, write enable and the ALU-result write select. It sits directly upstream of the combined register-file/ALU block and consumes its ZF/OF flags. One instruction retires every 4 cycles until a halt or an illegal instruction is reached.

---
 rtl/rtype_seq_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rtype_seq_ctrl.sv
// rtl/rtype_seq_ctrl.sv - 4-cycle fetch/decode/exec/writeback sequencer for MIPS R-type instructions
// Optional feature macro: RTYPE_OF_TRAP_EN (add/sub overflow traps to ERROR instead of writing back)
module rtype_seq_ctrl #(
    parameter int PC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     inst_data,
    input  logic            ZF,
    input  logic            OF,
    output logic [PC_W-1:0] inst_addr,
    output logic [4:0]      R_Addr_A,
    output logic [4:0]      R_Addr_B,
    output logic [4:0]      W_Addr,
    output logic [3:0]      ALU_OP,
    output logic            Write_Reg,
    output logic            write_F,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            flag_Z,
    output logic            flag_O,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERROR
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [4:0]      ir_rs;
    logic [4:0]      ir_rt;
    logic [4:0]      ir_rd;
    logic [3:0]      alu_op;
    logic [4:0]      dec;
    logic            unused_shamt;

    // {supported, alu_op} for the funct field of the word currently on the ROM bus
    function automatic logic [4:0] decode_funct(input logic [5:0] funct);
        case (funct)
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            6'b100110: return 5'b1_0010;
            6'b100111: return 5'b1_0011;
            6'b100000: return 5'b1_0100;
            6'b100010: return 5'b1_0101;
            6'b101010: return 5'b1_0110;
            6'b000100: return 5'b1_0111;
            default:   return 5'b0_0000;
        endcase
    endfunction

    assign dec          = decode_funct(inst_data[5:0]);
    assign unused_shamt = ^inst_data[10:6];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir_rs   <= '0;
            ir_rt   <= '0;
            ir_rd   <= '0;
            alu_op  <= '0;
            flag_Z  <= 1'b0;
            flag_O  <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        pc      <= '0;
                        flag_Z  <= 1'b0;
                        flag_O  <= 1'b0;
                        retired <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir_rs  <= inst_data[25:21];
                    ir_rt  <= inst_data[20:16];
                    ir_rd  <= inst_data[15:11];
                    alu_op <= dec[3:0];
                    if (inst_data[31:26] == 6'b111111)
                        state <= S_HALT;
                    else if (inst_data[31:26] == 6'b000000 && dec[4])
                        state <= S_EXEC;
                    else
                        state <= S_ERROR;
                end
                S_EXEC: begin
                    flag_Z <= ZF;
                    flag_O <= OF;
`ifdef RTYPE_OF_TRAP_EN
                    state  <= (OF && (alu_op == 4'b0100 || alu_op == 4'b0101)) ? S_ERROR : S_WB;
`else
                    state  <= S_WB;
`endif
                end
                S_WB: begin
                    pc <= pc + 1'b1;
                    if (retired != 16'hFFFF)
                        retired <= retired + 16'd1;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write enable is a pure decode of the WB state, so an async reset kills it at once
    assign Write_Reg = (state == S_WB) && (ir_rd != 5'd0);
    assign write_F   = 1'b1;
    assign inst_addr = pc;
    assign R_Addr_A  = ir_rs;
    assign R_Addr_B  = ir_rt;
    assign W_Addr    = ir_rd;
    assign ALU_OP    = alu_op;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
    assign done      = (state == S_HALT);
    assign err       = (state == S_ERROR);

endmodule
